// File: rtl/dmc_multiport_arb.sv
// N-port round-robin front end for the DDR controller app_* interface.
// Single-beat reads/writes; an in-order tag FIFO steers read returns back to the issuing port.
module dmc_multiport_arb #(
    parameter int NPORTS    = 4,
    parameter int ADDR_W    = 28,
    parameter int DATA_W    = 64,
    parameter int TAG_DEPTH = 8,
    localparam int MASK_W   = DATA_W / 8,
    localparam int TAG_W    = $clog2(TAG_DEPTH),
    localparam int CNT_W    = TAG_W + 1,
    localparam int PORT_W   = $clog2(NPORTS)
) (
    input  logic                     ui_clk_i,
    input  logic                     ui_rstn_i,
    input  logic                     init_calib_complete_i,
    input  logic [NPORTS-1:0]        req_valid_i,
    output logic [NPORTS-1:0]        req_ready_o,
    input  logic [NPORTS-1:0]        req_rd_i,
    input  logic [NPORTS*ADDR_W-1:0] req_addr_i,
    input  logic [NPORTS*DATA_W-1:0] req_wdata_i,
    input  logic [NPORTS*MASK_W-1:0] req_wmask_i,
    output logic [NPORTS-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]        rsp_data_o,
    output logic [ADDR_W-1:0]        app_addr_o,
    output logic [2:0]               app_cmd_o,
    output logic                     app_en_o,
    output logic [DATA_W-1:0]        app_wdf_data_o,
    output logic [MASK_W-1:0]        app_wdf_mask_o,
    output logic                     app_wdf_wren_o,
    output logic                     app_wdf_end_o,
    input  logic                     app_rdy_i,
    input  logic                     app_wdf_rdy_i,
    input  logic [DATA_W-1:0]        app_rd_data_i,
    input  logic                     app_rd_data_valid_i,
    output logic [CNT_W-1:0]         rd_outstanding_o,
    output logic                     err_o
);

    typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;

    state_t              r_state;
    logic [PORT_W-1:0]   r_rr_ptr;
    logic [PORT_W-1:0]   r_port;
    logic                r_rd;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [MASK_W-1:0]   r_wmask;
    logic                r_app_en;
    logic                r_wdf_wren;
    logic                r_cmd_done;
    logic                r_data_done;

    logic [PORT_W-1:0]   r_tag_mem [TAG_DEPTH];
    logic [TAG_W-1:0]    r_wr_ptr;
    logic [TAG_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_full;
    logic [NPORTS-1:0]   r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_err;

    logic [ADDR_W-1:0]   w_addr  [NPORTS];
    logic [DATA_W-1:0]   w_wdata [NPORTS];
    logic [MASK_W-1:0]   w_wmask [NPORTS];
    logic [NPORTS-1:0]   w_elig;
    logic [NPORTS-1:0]   w_rsp_sel;
    logic                w_grant_valid;
    logic [PORT_W-1:0]   w_grant_port;
    logic [PORT_W-1:0]   w_idx;
    logic                w_cmd_fire;
    logic                w_data_fire;
    logic                w_leave;
    logic                w_push;
    logic                w_pop;
    logic [PORT_W-1:0]   w_head_tag;
    logic [CNT_W-1:0]    w_count_next;

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_port
            assign w_addr[gi]  = req_addr_i[gi*ADDR_W +: ADDR_W];
            assign w_wdata[gi] = req_wdata_i[gi*DATA_W +: DATA_W];
            assign w_wmask[gi] = req_wmask_i[gi*MASK_W +: MASK_W];
            // Registered full flag: a pop in the same cycle cannot unblock a read.
            assign w_elig[gi]  = req_valid_i[gi] & init_calib_complete_i & (~req_rd_i[gi] | ~r_full);
            assign req_ready_o[gi] = w_leave & (r_port == PORT_W'(gi));
            assign w_rsp_sel[gi]   = (w_head_tag == PORT_W'(gi));
        end
    endgenerate

    // Scan downwards so the first eligible port at or after the pointer wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_port  = '0;
        w_idx         = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            w_idx = PORT_W'((int'(r_rr_ptr) + k) % NPORTS);
            if (w_elig[w_idx]) begin
                w_grant_valid = 1'b1;
                w_grant_port  = w_idx;
            end
        end
    end

    assign w_cmd_fire  = r_app_en & app_rdy_i;
    assign w_data_fire = r_wdf_wren & app_wdf_rdy_i;
    assign w_leave     = (r_state == ST_ISSUE) &
                         (r_rd ? w_cmd_fire
                               : ((r_cmd_done | w_cmd_fire) & (r_data_done | w_data_fire)));
    assign w_push      = w_leave & r_rd;
    assign w_pop       = app_rd_data_valid_i & (r_count != '0);
    assign w_head_tag  = r_tag_mem[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + CNT_W'(1);
        else if (!w_push && w_pop)
            w_count_next = r_count - CNT_W'(1);
    end

    always_ff @(posedge ui_clk_i or negedge ui_rstn_i) begin
        if (!ui_rstn_i) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_port      <= '0;
            r_rd        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wmask     <= '0;
            r_app_en    <= 1'b0;
            r_wdf_wren  <= 1'b0;
            r_cmd_done  <= 1'b0;
            r_data_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_port      <= w_grant_port;
                        r_rd        <= req_rd_i[w_grant_port];
                        r_addr      <= w_addr[w_grant_port];
                        r_wdata     <= w_wdata[w_grant_port];
                        r_wmask     <= w_wmask[w_grant_port];
                        r_app_en    <= 1'b1;
                        r_wdf_wren  <= ~req_rd_i[w_grant_port];
                        r_cmd_done  <= 1'b0;
                        r_data_done <= 1'b0;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_leave) begin
                        r_app_en   <= 1'b0;
                        r_wdf_wren <= 1'b0;
                        r_rr_ptr   <= (r_port == PORT_W'(NPORTS - 1)) ? '0 : r_port + PORT_W'(1);
                        r_state    <= ST_IDLE;
                    end else begin
                        if (w_cmd_fire) begin
                            r_app_en   <= 1'b0;
                            r_cmd_done <= 1'b1;
                        end
                        if (w_data_fire) begin
                            r_wdf_wren  <= 1'b0;
                            r_data_done <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ui_clk_i) begin
        if (w_push)
            r_tag_mem[r_wr_ptr] <= r_port;
    end

    always_ff @(posedge ui_clk_i or negedge ui_rstn_i) begin
        if (!ui_rstn_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + TAG_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + TAG_W'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(TAG_DEPTH));
            if (w_pop) begin
                r_rsp_valid <= w_rsp_sel;
                r_rsp_data  <= app_rd_data_i;
            end else begin
                r_rsp_valid <= '0;
            end
            if (app_rd_data_valid_i && (r_count == '0))
                r_err <= 1'b1;
        end
    end

    assign app_addr_o       = r_addr;
    assign app_cmd_o        = {2'b00, r_rd};
    assign app_en_o         = r_app_en;
    assign app_wdf_data_o   = r_wdata;
    assign app_wdf_mask_o   = r_wmask;
    assign app_wdf_wren_o   = r_wdf_wren;
    assign app_wdf_end_o    = r_wdf_wren;
    assign rsp_valid_o      = r_rsp_valid;
    assign rsp_data_o       = r_rsp_data;
    assign rd_outstanding_o = r_count;
    assign err_o            = r_err;

endmodule

// File: tb/tb_dmc_multiport_arb.sv
// Directed bench for dmc_multiport_arb: acceptances and read returns are scoreboarded
// with their expected cycle, directed checks cover calibration, reset, write split, full FIFO and error.
module tb_dmc_multiport_arb;

    localparam int NP = 4;
    localparam int AW = 28;
    localparam int DW = 64;
    localparam int MW = DW / 8;

    logic              ui_clk_i = 1'b0;
    logic              ui_rstn_i;
    logic              init_calib_complete_i;
    logic [NP-1:0]     req_valid_i;
    logic [NP-1:0]     req_ready_o;
    logic [NP-1:0]     req_rd_i;
    logic [NP*AW-1:0]  req_addr_i;
    logic [NP*DW-1:0]  req_wdata_i;
    logic [NP*MW-1:0]  req_wmask_i;
    logic [NP-1:0]     rsp_valid_o;
    logic [DW-1:0]     rsp_data_o;
    logic [AW-1:0]     app_addr_o;
    logic [2:0]        app_cmd_o;
    logic              app_en_o;
    logic [DW-1:0]     app_wdf_data_o;
    logic [MW-1:0]     app_wdf_mask_o;
    logic              app_wdf_wren_o;
    logic              app_wdf_end_o;
    logic              app_rdy_i;
    logic              app_wdf_rdy_i;
    logic [DW-1:0]     app_rd_data_i;
    logic              app_rd_data_valid_i;
    logic [3:0]        rd_outstanding_o;
    logic              err_o;

    dmc_multiport_arb #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(8)) dut (
        .ui_clk_i(ui_clk_i), .ui_rstn_i(ui_rstn_i), .init_calib_complete_i(init_calib_complete_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rd_i(req_rd_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .app_addr_o(app_addr_o), .app_cmd_o(app_cmd_o), .app_en_o(app_en_o),
        .app_wdf_data_o(app_wdf_data_o), .app_wdf_mask_o(app_wdf_mask_o),
        .app_wdf_wren_o(app_wdf_wren_o), .app_wdf_end_o(app_wdf_end_o),
        .app_rdy_i(app_rdy_i), .app_wdf_rdy_i(app_wdf_rdy_i),
        .app_rd_data_i(app_rd_data_i), .app_rd_data_valid_i(app_rd_data_valid_i),
        .rd_outstanding_o(rd_outstanding_o), .err_o(err_o)
    );

    always #5 ui_clk_i = ~ui_clk_i;

    typedef struct { int port; int cyc; logic [AW-1:0] addr; logic rd; } acc_t;
    typedef struct { int port; int cyc; logic [DW-1:0] data; } rsp_t;

    acc_t          acc_q[$];
    rsp_t          rsp_q[$];
    acc_t          a_mon;
    rsp_t          r_mon;
    int            n_assert = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    logic [NP-1:0] acc_last = '0;
    bit            auto_drop = 1'b0;
    int            c0;
    int            c2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock step; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge ui_clk_i);
        #1;
        if (auto_drop)
            req_valid_i = req_valid_i & ~acc_last;
    endtask

    task automatic set_req(input int p, input logic rd, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [MW-1:0] mask);
        req_valid_i[p]            = 1'b1;
        req_rd_i[p]               = rd;
        req_addr_i[p*AW +: AW]    = addr;
        req_wdata_i[p*DW +: DW]   = data;
        req_wmask_i[p*MW +: MW]   = mask;
    endtask

    task automatic push_acc(input int p, input int c, input logic [AW-1:0] addr, input logic rd);
        acc_t e;
        e.port = p; e.cyc = c; e.addr = addr; e.rd = rd;
        acc_q.push_back(e);
    endtask

    task automatic ret_data(input int p, input logic [DW-1:0] d);
        rsp_t e;
        app_rd_data_valid_i = 1'b1;
        app_rd_data_i       = d;
        e.port = p; e.cyc = cyc + 2; e.data = d;
        rsp_q.push_back(e);
    endtask

    // Scoreboard side: every acceptance and read return is popped and compared here.
    always @(negedge ui_clk_i) begin
        cyc++;
        acc_last = req_ready_o;
        if (req_ready_o != '0) begin
            if (acc_q.size() == 0) begin
                check("acc_unexpected", 64'(req_ready_o), 64'(0));
            end else begin
                a_mon = acc_q.pop_front();
                $display("accept port=%0d cyc=%0d addr=%0h cmd=%0d", a_mon.port, cyc, app_addr_o, app_cmd_o);
                check("acc_port", 64'(req_ready_o), 64'(4'(1) << a_mon.port));
                check("acc_cyc", 64'(cyc), 64'(a_mon.cyc));
                check("acc_addr", 64'(app_addr_o), 64'(a_mon.addr));
                check("acc_cmd", 64'(app_cmd_o), 64'({2'b00, a_mon.rd}));
            end
        end
        if (rsp_valid_o != '0) begin
            if (rsp_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid_o), 64'(0));
            end else begin
                r_mon = rsp_q.pop_front();
                $display("return port=%0d cyc=%0d data=%0h", r_mon.port, cyc, rsp_data_o);
                check("rsp_port", 64'(rsp_valid_o), 64'(4'(1) << r_mon.port));
                check("rsp_cyc", 64'(cyc), 64'(r_mon.cyc));
                check("rsp_data", rsp_data_o, r_mon.data);
            end
        end
    end

    initial begin
        ui_rstn_i = 1'b0; init_calib_complete_i = 1'b0;
        req_valid_i = '0; req_rd_i = '0; req_addr_i = '0; req_wdata_i = '0; req_wmask_i = '0;
        app_rdy_i = 1'b1; app_wdf_rdy_i = 1'b1; app_rd_data_i = '0; app_rd_data_valid_i = 1'b0;

        // Reset state
        repeat (3) step();
        @(negedge ui_clk_i);
        check("rst_app_en", 64'(app_en_o), 64'(0));
        check("rst_wren", 64'(app_wdf_wren_o), 64'(0));
        check("rst_ready", 64'(req_ready_o), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
        check("rst_outstanding", 64'(rd_outstanding_o), 64'(0));
        check("rst_err", 64'(err_o), 64'(0));
        step();
        ui_rstn_i = 1'b1;

        // Calibration low blocks every grant
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, AW'(32'h100 + p), DW'(p), '0);
        repeat (20) begin
            step();
            @(negedge ui_clk_i);
            check("calib_app_en", 64'(app_en_o), 64'(0));
            check("calib_ready", 64'(req_ready_o), 64'(0));
        end

        // Async reset in the middle of ISSUE
        step();
        init_calib_complete_i = 1'b1;
        app_rdy_i = 1'b0;
        step();
        @(negedge ui_clk_i);
        check("issue_app_en", 64'(app_en_o), 64'(1));
        check("issue_addr", 64'(app_addr_o), 64'(32'h100));
        #2 ui_rstn_i = 1'b0;
        #1;
        check("midrst_app_en", 64'(app_en_o), 64'(0));
        check("midrst_wren", 64'(app_wdf_wren_o), 64'(0));
        check("midrst_addr", 64'(app_addr_o), 64'(0));
        req_valid_i = '0;
        step();
        step();
        ui_rstn_i = 1'b1;
        app_rdy_i = 1'b1;

        // Fairness: four held writes accepted 0,1,2,3,0,1,2,3, one every 2 cycles
        step();
        auto_drop = 1'b0;
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, AW'(32'h200 + p), DW'(64'hA0 + p), MW'(p));
        c0 = cyc;
        for (int i = 0; i < 8; i++) push_acc(i % NP, c0 + 2 + 2 * i, AW'(32'h200 + i % NP), 1'b0);
        repeat (16) step();
        req_valid_i = '0;
        auto_drop = 1'b1;

        // Write with write-data ready delayed 3 cycles
        step();
        app_wdf_rdy_i = 1'b0;
        set_req(1, 1'b0, AW'(32'h33), 64'h1122334455667788, 8'h0F);
        c0 = cyc;
        push_acc(1, c0 + 5, AW'(32'h33), 1'b0);
        @(negedge ui_clk_i);
        check("wsplit_c1_en", 64'(app_en_o), 64'(0));
        step();
        @(negedge ui_clk_i);
        check("wsplit_c2_en", 64'(app_en_o), 64'(1));
        check("wsplit_c2_wren", 64'(app_wdf_wren_o), 64'(1));
        check("wsplit_c2_end", 64'(app_wdf_end_o), 64'(1));
        check("wsplit_c2_cmd", 64'(app_cmd_o), 64'(0));
        check("wsplit_data", app_wdf_data_o, 64'h1122334455667788);
        check("wsplit_mask", 64'(app_wdf_mask_o), 64'h0F);
        step();
        @(negedge ui_clk_i);
        check("wsplit_c3_en", 64'(app_en_o), 64'(0));
        check("wsplit_c3_wren", 64'(app_wdf_wren_o), 64'(1));
        step();
        @(negedge ui_clk_i);
        check("wsplit_c4_wren", 64'(app_wdf_wren_o), 64'(1));
        step();
        app_wdf_rdy_i = 1'b1;
        @(negedge ui_clk_i);
        check("wsplit_c5_wren", 64'(app_wdf_wren_o), 64'(1));
        step();
        @(negedge ui_clk_i);
        check("wsplit_c6_wren", 64'(app_wdf_wren_o), 64'(0));
        check("wsplit_c6_en", 64'(app_en_o), 64'(0));

        // Read steering: pointer is at 2, so port2 then port0 (wrap)
        step();
        set_req(2, 1'b1, AW'(32'hAAA), '0, '0);
        set_req(0, 1'b1, AW'(32'hBBB), '0, '0);
        c0 = cyc;
        push_acc(2, c0 + 2, AW'(32'hAAA), 1'b1);
        push_acc(0, c0 + 4, AW'(32'hBBB), 1'b1);
        repeat (4) step();
        @(negedge ui_clk_i);
        check("steer_outstanding", 64'(rd_outstanding_o), 64'(2));
        step();
        ret_data(2, 64'hD1D1D1D1_00000001);
        step();
        ret_data(0, 64'hD2D2D2D2_00000002);
        step();
        app_rd_data_valid_i = 1'b0;
        step();
        step();
        @(negedge ui_clk_i);
        check("steer_drained", 64'(rd_outstanding_o), 64'(0));

        // Full FIFO: 8 reads from port1, then a write still wins while the 9th read waits
        step();
        auto_drop = 1'b0;
        set_req(1, 1'b1, AW'(32'hC0C), '0, '0);
        c0 = cyc;
        for (int i = 0; i < 8; i++) push_acc(1, c0 + 2 + 2 * i, AW'(32'hC0C), 1'b1);
        repeat (16) step();
        set_req(3, 1'b0, AW'(32'hE0E), 64'h5A5A, 8'h00);
        push_acc(3, c0 + 18, AW'(32'hE0E), 1'b0);
        auto_drop = 1'b1;
        @(negedge ui_clk_i);
        check("full_outstanding", 64'(rd_outstanding_o), 64'(8));
        step();
        step();
        @(negedge ui_clk_i);
        check("full_blocked_a", 64'(app_en_o), 64'(0));
        step();
        @(negedge ui_clk_i);
        check("full_blocked_b", 64'(app_en_o), 64'(0));
        step();
        c2 = cyc;
        ret_data(1, 64'hD3D3D3D3_00000003);
        push_acc(1, c2 + 3, AW'(32'hC0C), 1'b1);
        @(negedge ui_clk_i);
        check("full_pop_cycle_en", 64'(app_en_o), 64'(0));
        step();
        app_rd_data_valid_i = 1'b0;
        repeat (3) step();
        @(negedge ui_clk_i);
        check("full_refill", 64'(rd_outstanding_o), 64'(8));
        step();
        for (int i = 0; i < 8; i++) begin
            ret_data(1, 64'hF000_0000_0000_0000 | 64'(i));
            step();
        end
        app_rd_data_valid_i = 1'b0;
        step();
        step();
        @(negedge ui_clk_i);
        check("drain_outstanding", 64'(rd_outstanding_o), 64'(0));
        check("drain_rsp_hold", rsp_data_o, 64'hF000_0000_0000_0007);
        check("drain_rsp_valid", 64'(rsp_valid_o), 64'(0));

        // Read data with an empty FIFO sets the sticky error
        check("err_before", 64'(err_o), 64'(0));
        step();
        app_rd_data_valid_i = 1'b1;
        app_rd_data_i = 64'hDEAD;
        step();
        app_rd_data_valid_i = 1'b0;
        @(negedge ui_clk_i);
        check("err_set", 64'(err_o), 64'(1));
        check("err_no_rsp", 64'(rsp_valid_o), 64'(0));
        repeat (3) step();
        @(negedge ui_clk_i);
        check("err_sticky", 64'(err_o), 64'(1));
        #2 ui_rstn_i = 1'b0;
        #1;
        check("err_cleared", 64'(err_o), 64'(0));

        check("acc_queue_empty", 64'(acc_q.size()), 64'(0));
        check("rsp_queue_empty", 64'(rsp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
